// File: rtl/traffic_light_controller.sv
// Main/side intersection Moore FSM with pedestrian phase; drives lamps and loads the external phase timer.
// Latency: honoured expired -> state change next edge -> start_timer pulse the edge after.
// Backpressure: none; expired is ignored until the freshly loaded timer is armed.
module traffic_light_controller #(
    parameter logic [3:0] T_BASE = 4'd6,
    parameter logic [3:0] T_EXT  = 4'd3,
    parameter logic [3:0] T_YEL  = 4'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        SIDE_GREEN  = 3'd2,
        SIDE_EXT    = 3'd3,
        SIDE_YELLOW = 3'd4,
        WALK        = 3'd5
    } state_t;

    state_t state, state_next;
    logic   walk_pend;
    logic   armed;
    logic   entry_q;
    logic   honoured;
    logic   entry_d;

    // Blanking during the load cycle hides stale expired from the previous phase.
    assign honoured = expired & armed & ~start_timer;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= MAIN_GREEN;
            walk_pend   <= 1'b0;
            start_timer <= 1'b0;
            armed       <= 1'b0;
            entry_q     <= 1'b1;
        end else begin
            state       <= state_next;
            entry_q     <= entry_d;
            start_timer <= entry_q;
            if (honoured || entry_q)
                armed <= 1'b0;
            else if (start_timer)
                armed <= 1'b1;
            if (honoured && state == WALK)
                walk_pend <= 1'b0;
            else if (walk_request && state != WALK)
                walk_pend <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        entry_d     = honoured;
        main_lights = 3'b100;
        side_lights = 3'b100;
        walk        = 1'b0;
        value       = T_BASE;
        case (state)
            MAIN_GREEN: begin
                main_lights = 3'b001;
                if (honoured)
                    state_next = (sensor || walk_pend) ? MAIN_YELLOW : MAIN_GREEN;
            end
            MAIN_YELLOW: begin
                main_lights = 3'b010;
                value       = T_YEL;
                if (honoured)
                    state_next = SIDE_GREEN;
            end
            SIDE_GREEN: begin
                side_lights = 3'b001;
                if (honoured)
                    state_next = sensor ? SIDE_EXT : SIDE_YELLOW;
            end
            SIDE_EXT: begin
                side_lights = 3'b001;
                value       = T_EXT;
                if (honoured)
                    state_next = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                side_lights = 3'b010;
                value       = T_YEL;
                if (honoured)
                    state_next = walk_pend ? WALK : MAIN_GREEN;
            end
            WALK: begin
                walk  = 1'b1;
                value = T_EXT;
                if (honoured)
                    state_next = MAIN_GREEN;
            end
            default: begin
                state_next = MAIN_GREEN;
                entry_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: phase sequencing, timer handshake, walk latch, reset abort.
module tb_traffic_light_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       expired = 1'b0;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;
    logic       run = 1'b0;

    int checks = 0;
    int errors = 0;

    // {main_lights, side_lights, walk, value}
    localparam logic [10:0] MG = {3'b001, 3'b100, 1'b0, 4'd6};
    localparam logic [10:0] MY = {3'b010, 3'b100, 1'b0, 4'd2};
    localparam logic [10:0] SG = {3'b100, 3'b001, 1'b0, 4'd6};
    localparam logic [10:0] SE = {3'b100, 3'b001, 1'b0, 4'd3};
    localparam logic [10:0] SY = {3'b100, 3'b010, 1'b0, 4'd2};
    localparam logic [10:0] WK = {3'b100, 3'b100, 1'b1, 4'd3};

    logic [10:0] obs;
    assign obs = {main_lights, side_lights, walk, value};

    traffic_light_controller dut (
        .clock        (clock),
        .reset        (reset),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (expired),
        .start_timer  (start_timer),
        .value        (value),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk         (walk)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%03h want=%03h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From an armed idle cycle: one expired pulse, then entry, load and arm of the next phase.
    task automatic fire(input string tag, input logic [10:0] nxt);
        expired = 1'b1;
        tick();
        expired = 1'b0;
        chk({tag, "_entry"}, obs, nxt);
        chk({tag, "_nostart"}, 11'(start_timer), 11'd0);
        tick();
        chk({tag, "_start"}, 11'(start_timer), 11'd1);
        chk({tag, "_load"}, obs, nxt);
        tick();
        chk({tag, "_armed"}, 11'(start_timer), 11'd0);
    endtask

    always @(negedge clock) begin
        if (run)
            chk("safety", 11'(!(main_lights[0] && side_lights[0]) && (main_lights[2] || side_lights[2])
                              && $onehot(main_lights) && $onehot(side_lights)), 11'd1);
    end

    initial begin
        logic [10:0] seq [5];
        seq[0] = MY; seq[1] = SG; seq[2] = SE; seq[3] = SY; seq[4] = MG;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            run = 1'b1;
            chk("rst_lamps", obs, MG);
            chk("rst_start", 11'(start_timer), 11'd0);
        end
        reset = 1'b0;
        tick();
        chk("post_rst_start", 11'(start_timer), 11'd1);
        chk("post_rst_value", 11'(value), 11'd6);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_restart", 11'(start_timer), 11'd0);
        end

        // no side traffic: main green re-entries
        fire("mg_reenter1", MG);
        fire("mg_reenter2", MG);

        // sensor toggled between expirations has no effect
        sensor = 1'b1;
        tick();
        tick();
        sensor = 1'b0;
        fire("sensor_toggle", MG);

        // full side cycle with extension
        sensor = 1'b1;
        fire("s_my", MY);
        fire("s_sg", SG);
        fire("s_se", SE);
        fire("s_sy", SY);
        fire("s_mg", MG);

        // pedestrian phase
        sensor = 1'b0;
        walk_request = 1'b1;
        tick();
        walk_request = 1'b0;
        chk("walk_pend_set", 11'(dut.walk_pend), 11'd1);
        fire("w_my", MY);
        fire("w_sg", SG);
        fire("w_sy", SY);
        fire("w_wk", WK);
        walk_request = 1'b1;
        tick();
        walk_request = 1'b0;
        fire("w_mg", MG);
        chk("walk_pend_clr", 11'(dut.walk_pend), 11'd0);
        fire("w_no_repeat", MG);

        // expired held high: one transition per three cycles
        sensor = 1'b1;
        expired = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_entry", obs, seq[i]);
            chk("hold_nostart", 11'(start_timer), 11'd0);
            tick();
            chk("hold_start", 11'(start_timer), 11'd1);
            chk("hold_load", obs, seq[i]);
            if (i == 4) expired = 1'b0;
            tick();
            chk("hold_armed", obs, seq[i]);
        end
        tick();
        chk("hold_released", obs, MG);

        // reset mid SIDE_EXT
        fire("r1_my", MY);
        fire("r1_sg", SG);
        fire("r1_se", SE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r1_lamps", obs, MG);
        chk("r1_nostart", 11'(start_timer), 11'd0);
        tick();
        chk("r1_start", 11'(start_timer), 11'd1);
        chk("r1_value", 11'(value), 11'd6);
        tick();

        // reset mid WALK
        sensor = 1'b0;
        walk_request = 1'b1;
        tick();
        walk_request = 1'b0;
        fire("r2_my", MY);
        fire("r2_sg", SG);
        fire("r2_sy", SY);
        fire("r2_wk", WK);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r2_lamps", obs, MG);
        chk("r2_walk_pend", 11'(dut.walk_pend), 11'd0);
        tick();
        chk("r2_start", 11'(start_timer), 11'd1);
        chk("r2_value", 11'(value), 11'd6);
        tick();
        fire("r2_after", MG);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
